// File: rtl/dmem_lsu_arbiter.sv
// dmem_lsu_arbiter: shares one word-wide data memory between two LSU lanes.
// Round-robin grant, one outstanding request, sub-word loads by lane
// extraction and sub-word stores by read-modify-write.
module dmem_lsu_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0]             req_we,
    input  logic [1:0][1:0]        req_size,
    input  logic [1:0]             req_unsigned,
    input  logic [1:0][ADDR_W-1:0] req_addr,
    input  logic [1:0][31:0]       req_wdata,
    output logic [1:0]             resp_valid,
    output logic [1:0]             resp_err,
    output logic [1:0][31:0]       resp_rdata,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [31:0]            mem_wdata,
    output logic                   mem_read,
    output logic                   mem_write,
    input  logic [31:0]            mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    state_t              state, state_d;
    logic                rr_ptr;
    logic                lane_q, we_q, uns_q;
    logic [1:0]          size_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q, merged_q;

    logic                grant_any, grant_lane;
    logic                misaligned, subword;
    logic [7:0]          byte_sel;
    logic [15:0]         half_sel;
    logic [31:0]         load_data, merged;
    logic                rd_en, wr_en;

    // Round-robin grant: only in IDLE, one lane at most, pointer breaks ties.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
        grant_any  = 1'b0;
        grant_lane = 1'b0;
        if (state == IDLE) begin
            case (req_valid)
                2'b01:   begin grant_any = 1'b1; grant_lane = 1'b0;   end
                2'b10:   begin grant_any = 1'b1; grant_lane = 1'b1;   end
                2'b11:   begin grant_any = 1'b1; grant_lane = rr_ptr; end
                default: ;
            endcase
        end
        req_ready = (grant_any && rst_n) ? (2'b01 << grant_lane) : 2'b00;
    end

    // Request decode, load lane extraction/extension and store merge.
    always_comb begin
        misaligned = (size_q == SZ_ILL) ||
                     (size_q == SZ_HALF && addr_q[0]) ||
                     (size_q == SZ_WORD && addr_q[1:0] != 2'b00);
        subword    = (size_q == SZ_BYTE) || (size_q == SZ_HALF);
        byte_sel   = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        half_sel   = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            SZ_BYTE: load_data = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data = {{16{~uns_q & half_sel[15]}}, half_sel};
            default: load_data = mem_rdata;
        endcase
        merged = mem_rdata;
        if (size_q == SZ_BYTE) merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else                   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    // Next state and memory-side outputs; strobes are killed while in reset.
    always_comb begin
        state_d   = state;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: if (grant_any) state_d = ACCESS;
            ACCESS: begin
                mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
                if (misaligned) begin
                    state_d = IDLE;
                end else if (!we_q) begin
                    rd_en   = 1'b1;
                    state_d = IDLE;
                end else if (!subword) begin
                    wr_en     = 1'b1;
                    mem_wdata = wdata_q;
                    state_d   = IDLE;
                end else begin
                    rd_en   = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
                wr_en     = 1'b1;
                mem_wdata = merged_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        mem_read  = rd_en & rst_n;
        mem_write = wr_en & rst_n;
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Request capture, pointer update and response generation.
    always_ff @(posedge clk) begin
        // NOTE: the latched request fields are always written before use, so only control and response flops are reset.
        if (!rst_n) begin
            rr_ptr     <= 1'b0;
            resp_valid <= 2'b00;
            resp_err   <= 2'b00;
            resp_rdata <= '0;
        end else begin
            resp_valid <= 2'b00;
            resp_err   <= 2'b00;
            case (state)
                IDLE: if (grant_any) begin
                    lane_q  <= grant_lane;
                    we_q    <= req_we[grant_lane];
                    size_q  <= req_size[grant_lane];
                    uns_q   <= req_unsigned[grant_lane];
                    addr_q  <= req_addr[grant_lane];
                    wdata_q <= req_wdata[grant_lane];
                    rr_ptr  <= ~grant_lane;
                end
                ACCESS: begin
                    if (misaligned) begin
                        resp_valid[lane_q] <= 1'b1;
                        resp_err[lane_q]   <= 1'b1;
                        resp_rdata[lane_q] <= '0;
                    end else if (!we_q) begin
                        resp_valid[lane_q] <= 1'b1;
                        resp_rdata[lane_q] <= load_data;
                    end else if (!subword) begin
                        resp_valid[lane_q] <= 1'b1;
                    end else begin
                        merged_q <= merged;
                    end
                end
                WRITE: resp_valid[lane_q] <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu_arbiter.sv
// Bench for dmem_lsu_arbiter: directed vector table, hand-written corner
// sequences, and randomized traffic against a byte-level reference memory.
module tb_dmem_lsu_arbiter;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [1:0]        req_valid = '0;
  logic [1:0]        req_ready;
  logic [1:0]        req_we = '0;
  logic [1:0][1:0]   req_size = '0;
  logic [1:0]        req_unsigned = '0;
  logic [1:0][31:0]  req_addr = '0;
  logic [1:0][31:0]  req_wdata = '0;
  logic [1:0]        resp_valid;
  logic [1:0]        resp_err;
  logic [1:0][31:0]  resp_rdata;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_rdata;

  dmem_lsu_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory seen by the DUT: 64 words, combinational read, preload port.
  logic [31:0] dut_mem [64];
  logic        pl_we = 1'b0;
  logic [5:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;
  assign mem_rdata = dut_mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (mem_write)  dut_mem[mem_addr[7:2]] <= mem_wdata;
    else if (pl_we) dut_mem[pl_idx] <= pl_data;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Protocol monitor: never read and write together, address word-aligned.
  always @(negedge clk) begin
    check("mem_rw_exclusive", 32'(mem_read & mem_write), 32'd0);
    check("mem_addr_aligned", 32'(mem_addr[1:0]), 32'd0);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic preload(input int idx, input logic [31:0] data);
    @(negedge clk);
    pl_we = 1'b1; pl_idx = 6'(idx); pl_data = data;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic drive(input logic lane, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    req_we[lane] = we; req_size[lane] = size; req_unsigned[lane] = uns;
    req_addr[lane] = addr; req_wdata[lane] = wdata;
  endtask

  typedef struct {
    logic        lane;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  logic        obs_rd [1:6];
  logic        obs_wr [1:6];
  logic [31:0] obs_wd [1:6];
  logic [31:0] obs_addr [1:6];

  // Issue one request on one lane; report latency and the response seen.
  task automatic run_txn(input vec_t v, output int lat, output logic err, output logic [31:0] rdata);
    bit acc;
    lat = -1; err = 1'bx; rdata = 'x; acc = 0;
    @(negedge clk);
    drive(v.lane, v.we, v.size, v.uns, v.addr, v.wdata);
    req_valid = 2'b01 << v.lane;
    for (int w = 0; w < 8 && !acc; w++) begin
      #1;
      if (req_ready[v.lane]) acc = 1;
      else @(negedge clk);
    end
    if (!acc) begin
      check("txn_accept_timeout", 32'd0, 32'd1);
      req_valid = '0;
      return;
    end
    @(posedge clk);
    for (int n = 1; n <= 6; n++) begin
      obs_rd[n] = 1'b0; obs_wr[n] = 1'b0; obs_wd[n] = '0; obs_addr[n] = '0;
    end
    for (int n = 1; n <= 6 && lat < 0; n++) begin
      @(negedge clk);
      if (n == 1) req_valid = '0;
      obs_rd[n] = mem_read; obs_wr[n] = mem_write;
      obs_wd[n] = mem_wdata; obs_addr[n] = mem_addr;
      if (resp_valid[v.lane]) begin
        lat = n; err = resp_err[v.lane]; rdata = resp_rdata[v.lane];
      end
    end
  endtask

  // Byte-granular reference memory for the randomized phase.
  logic [7:0] ref_mem [256];

  function automatic logic [31:0] ref_word(input int a);
    return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
  endfunction

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  vec_t vecs [16];

  initial begin
    int lat;
    logic err;
    logic [31:0] rdata;
    bit grants [4];
    int ng;
    bit acc;

    // Directed vectors: {lane, we, size, uns, addr, wdata, err, rdata, latency}.
    vecs[0]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h40, 32'hDEADBEEF, 1'b0, 32'h00000000, 2};
    vecs[1]  = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0,        1'b0, 32'hDEADBEEF, 2};
    vecs[2]  = '{1'b1, 1'b1, 2'd0, 1'b0, 32'h82, 32'h000000AA, 1'b0, 32'h00000000, 3};
    vecs[3]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h80, 32'h0,        1'b0, 32'h11AA3344, 2};
    vecs[4]  = '{1'b0, 1'b0, 2'd0, 1'b0, 32'h10, 32'h0,        1'b0, 32'hFFFFFF80, 2};
    vecs[5]  = '{1'b0, 1'b0, 2'd1, 1'b1, 32'h10, 32'h0,        1'b0, 32'h0000F080, 2};
    vecs[6]  = '{1'b0, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0,        1'b0, 32'h00000000, 2};
    vecs[7]  = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h21, 32'h0,        1'b1, 32'h00000000, 2};
    vecs[8]  = '{1'b0, 1'b0, 2'd3, 1'b0, 32'h20, 32'h0,        1'b1, 32'h00000000, 2};
    vecs[9]  = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h11, 32'h0,        1'b0, 32'h000000F0, 2};
    vecs[10] = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h42, 32'h1234BEEF, 1'b0, 32'h00000000, 3};
    vecs[11] = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0,        1'b0, 32'hBEEFBEEF, 2};
    vecs[12] = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h42, 32'h0,        1'b0, 32'hFFFFBEEF, 2};
    vecs[13] = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h41, 32'h5A5A5A5A, 1'b1, 32'h00000000, 2};
    vecs[14] = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h83, 32'h0,        1'b0, 32'h00000011, 2};
    vecs[15] = '{1'b0, 1'b0, 2'd0, 1'b0, 32'h82, 32'h0,        1'b0, 32'hFFFFFFAA, 2};

    // Reset with memory preload.
    rst_n = 1'b0;
    for (int w = 0; w < 64; w++) preload(w, 32'h0);
    preload(32'h80 >> 2, 32'h11223344);
    preload(32'h10 >> 2, 32'h0000F080);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_resp_err", 32'(resp_err), 32'd0);
    check("reset_rdata0", resp_rdata[0], 32'd0);
    check("reset_rdata1", resp_rdata[1], 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_mem_strobes", 32'({mem_read, mem_write}), 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);

    // Directed table.
    for (int i = 0; i < 16; i++) begin
      run_txn(vecs[i], lat, err, rdata);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      if (vecs[i].exp_err)
        check($sformatf("vec%0d_no_mem_access", i), 32'(obs_rd[1] | obs_wr[1]), 32'd0);
      if (i == 0) begin
        check("word_store_write_t1", 32'(obs_wr[1]), 32'd1);
        check("word_store_wdata_t1", obs_wd[1], 32'hDEADBEEF);
        check("word_store_addr_t1", obs_addr[1], 32'h40);
      end
      if (i == 2) begin
        check("rmw_read_t1", 32'({obs_rd[1], obs_wr[1]}), 32'b10);
        check("rmw_write_t2", 32'({obs_rd[2], obs_wr[2]}), 32'b01);
        check("rmw_wdata_t2", obs_wd[2], 32'h11AA3344);
        check("rmw_addr_t2", obs_addr[2], 32'h80);
      end
    end

    // Arbitration: both lanes hold valid after reset; grants alternate from lane 0.
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h80, 32'h0);
    req_valid = 2'b11;
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      #1;
      if (req_ready != 2'b00) begin
        check("arb_onehot", 32'($countones(req_ready)), 32'd1);
        grants[ng] = req_ready[1];
        ng++;
      end
      @(negedge clk);
    end
    req_valid = '0;
    check("arb_grant_count", 32'(ng), 32'd4);
    check("arb_order", 32'({grants[0], grants[1], grants[2], grants[3]}), 32'b0101);
    repeat (4) @(negedge clk);

    // Reset landing in WRITE of a byte store: no write, pointer back to lane 0.
    drive(1'b0, 1'b1, 2'd0, 1'b0, 32'h80, 32'h00000055);
    req_valid = 2'b01;
    #1;
    check("rstw_accept", 32'(req_ready), 32'b01);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    check("rstw_access_read", 32'(mem_read), 32'd1);
    @(posedge clk);
    #1;
    check("rstw_in_write", 32'(mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstw_write_gated", 32'({mem_read, mem_write}), 32'd0);
    @(posedge clk);
    #1;
    check("rstw_resp_valid", 32'(resp_valid), 32'd0);
    check("rstw_mem_unchanged", dut_mem[32'h80 >> 2], 32'h11AA3344);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    req_valid = 2'b11;
    #1;
    check("rstw_idle_ptr_lane0", 32'(req_ready), 32'b01);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    repeat (4) @(negedge clk);

    // Randomized traffic against the byte-level reference model.
    begin
      req_t pend_req [2];
      bit   pend [2];
      logic [31:0] exp_rd [2];
      int ptr, free_cyc, resp_cyc, resp_lane, noacc_cyc, resp_word;
      logic resp_is_err;

      @(negedge clk);
      rst_n = 1'b0;
      req_valid = '0;
      for (int w = 0; w < 64; w++) begin
        logic [31:0] d;
        d = $urandom;
        preload(w, d);
        for (int b = 0; b < 4; b++) ref_mem[4*w+b] = d[8*b +: 8];
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);

      ptr = 0; free_cyc = 0; resp_cyc = -1; resp_lane = 0; noacc_cyc = -1;
      resp_word = 0; resp_is_err = 1'b0;
      pend[0] = 0; pend[1] = 0;
      exp_rd[0] = '0; exp_rd[1] = '0;

      for (int cyc = 0; cyc < 3000; cyc++) begin
        int g;
        logic [1:0] exp_ready;
        logic [1:0] exp_rv;
        @(negedge clk);
        exp_rv = (cyc == resp_cyc) ? (2'b01 << resp_lane) : 2'b00;
        check("rnd_resp_valid", 32'(resp_valid), 32'(exp_rv));
        check("rnd_resp_err", 32'(resp_err), 32'(resp_is_err ? exp_rv : 2'b00));
        if (cyc == resp_cyc) begin
          check("rnd_rdata0", resp_rdata[0], exp_rd[0]);
          check("rnd_rdata1", resp_rdata[1], exp_rd[1]);
          check("rnd_mem_word", dut_mem[resp_word >> 2], ref_word(resp_word));
        end
        if (cyc == noacc_cyc)
          check("rnd_err_no_access", 32'({mem_read, mem_write}), 32'd0);

        for (int l = 0; l < 2; l++) begin
          if (!pend[l] && $urandom_range(0, 2) != 0) begin
            int s;
            s = $urandom_range(0, 9);
            pend_req[l].size  = (s < 3) ? 2'd0 : (s < 6) ? 2'd1 : (s < 9) ? 2'd2 : 2'd3;
            pend_req[l].we    = 1'($urandom_range(0, 1));
            pend_req[l].uns   = 1'($urandom_range(0, 1));
            pend_req[l].wdata = $urandom;
            pend_req[l].addr  = 32'($urandom_range(0, 255));
            if (pend_req[l].size != 2'd3 && $urandom_range(0, 3) != 0)
              pend_req[l].addr = pend_req[l].addr & ~((32'd1 << pend_req[l].size) - 32'd1);
            pend[l] = 1;
          end
          drive(1'(l), pend_req[l].we, pend_req[l].size, pend_req[l].uns,
                pend_req[l].addr, pend_req[l].wdata);
          req_valid[l] = pend[l];
        end
        #1;

        g = -1;
        if (cyc >= free_cyc) begin
          if (pend[0] && pend[1]) g = ptr;
          else if (pend[0])       g = 0;
          else if (pend[1])       g = 1;
        end
        exp_ready = (g >= 0) ? (2'b01 << g) : 2'b00;
        check("rnd_req_ready", 32'(req_ready), 32'(exp_ready));

        if (g >= 0) begin
          req_t r;
          int nb, a, lat_m;
          logic [31:0] v;
          r = pend_req[g];
          a = int'(r.addr);
          nb = (r.size == 2'd3) ? 8 : (1 << r.size);
          lat_m = 2;
          resp_is_err = (r.size == 2'd3) || (a % nb != 0);
          if (resp_is_err) begin
            exp_rd[g] = '0;
          end else if (!r.we) begin
            v = '0;
            for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[a+i]) << (8*i));
            if (!r.uns && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
            exp_rd[g] = v;
          end else begin
            for (int i = 0; i < nb; i++) ref_mem[a+i] = 8'((r.wdata >> (8*i)) & 32'hFF);
            if (nb < 4) lat_m = 3;
          end
          resp_cyc  = cyc + lat_m;
          free_cyc  = cyc + lat_m;
          resp_lane = g;
          resp_word = a & ~3;
          noacc_cyc = resp_is_err ? cyc + 1 : -1;
          ptr = 1 - g;
          pend[g] = 0;
        end
      end
      req_valid = '0;
      repeat (4) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_lsu_arbiter.md
Name: dmem_lsu_arbiter

Overview:
- Shares the single word-wide data memory between the two load/store lanes of the superscalar core.
- Round-robin arbitration and per-lane valid/ready request handshake.
- Sub-word loads: lane extraction with sign or zero extension.
- Sub-word stores: read-modify-write, because the memory port only writes full words.
- Sits between the issue-stage LSU lanes and the data memory; all memory-side signals are driven from this block.

Parameters:
- ADDR_W, 32, byte-address width of requests and of mem_addr.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  2  per-lane request valid (bit i = lane i).
- req_ready  out  2  per-lane request accepted this cycle.
- req_we  in  2  per-lane 1 = store, 0 = load.
- req_size  in  2x2  per-lane size: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  2  per-lane 1 = zero-extend load, 0 = sign-extend load.
- req_addr  in  2xADDR_W  per-lane byte address.
- req_wdata  in  2x32  per-lane store data, right-justified.
- resp_valid  out  2  per-lane one-cycle completion pulse.
- resp_err  out  2  per-lane misaligned or illegal request; qualified by resp_valid.
- resp_rdata  out  2x32  per-lane load result; held until that lane's next response.
- mem_addr  out  ADDR_W  word-aligned memory address (bits [1:0] always 00).
- mem_wdata  out  32  memory write data.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable.
- mem_rdata  in  32  combinational memory read data.

Behaviour:
- States: IDLE, ACCESS, WRITE.
- Reset (rst_n low at a clk edge):
  - state = IDLE, round-robin pointer = lane 0.
  - resp_valid = 00, resp_err = 00, resp_rdata = 0 for both lanes.
- mem_read and mem_write are gated by rst_n. A cycle with rst_n low never issues a memory access, including a reset landing mid-RMW in WRITE, so no partial store occurs.
- Handshake and arbitration:
  - req_ready is combinational and asserted only in IDLE, to at most one lane.
  - One lane valid: that lane is granted.
  - Both lanes valid: the lane named by the pointer is granted; after every grant the pointer moves to the other lane.
  - Requesters hold all req_* fields stable while req_valid=1 and req_ready=0.
- Accept:
  - On handshake, latch lane id, we, size, unsigned, addr and wdata; go to ACCESS.
  - The request fields are not sampled again after acceptance.
- IDLE outputs: mem_read = mem_write = 0, mem_addr = 0, mem_wdata = 0.
- ACCESS, driven from latched values: mem_addr = {addr[ADDR_W-1:2], 2'b00}.
  - Misaligned (half with addr[0]=1, word with addr[1:0]≠00) or size=11:
    - no memory access;
    - next edge: resp_valid=1 and resp_err=1 for the lane, resp_rdata = 0;
    - go to IDLE.
  - Load:
    - mem_read = 1.
    - Byte lane = addr[1:0]; half = mem_rdata[15:0] if addr[1]=0, else [31:16]; word = whole word.
    - Extend per the unsigned flag; register into resp_rdata[lane] with resp_valid pulse; go to IDLE.
  - Word store: mem_write = 1, mem_wdata = wdata; resp_valid pulse next edge; go to IDLE.
  - Sub-word store:
    - mem_read = 1.
    - Register the merged word: mem_rdata with the addressed byte/half replaced by wdata[7:0] or wdata[15:0].
    - Go to WRITE.
- WRITE: mem_write = 1, mem_read = 0, mem_wdata = merged word; resp_valid pulse next edge; go to IDLE.
- Latency, handshake at edge T:
  - load / word store / error: resp_valid high in cycle T+2;
  - sub-word store: resp_valid high in cycle T+3.
- The next request can be accepted in the same cycle resp_valid is high.
- resp_err is 0 on every non-error response. Stores leave resp_rdata unchanged.
- Never more than one outstanding request; never mem_read and mem_write together.

Test Plan:
- Word store/load: lane0 stores 0xDEADBEEF to 0x40, then loads 0x40 → mem_write in cycle T+1; load response 0xDEADBEEF in T+2, resp_err=0.
- Byte RMW:
  - preload 0x11223344 at 0x80;
  - lane1 stores byte 0xAA to 0x82 → mem_read in T+1, mem_write of 0x11AA3344 in T+2, resp_valid[1] in T+3.
- Sign/zero extension: word 0x0000F080 at 0x10:
  - signed byte load at 0x10 → 0xFFFFFF80;
  - unsigned half load at 0x10 → 0x0000F080;
  - signed half load at 0x12 → 0x00000000.
- Arbitration: both lanes hold req_valid continuously → grants alternate 0,1,0,1; no lane waits more than one grant.
- Errors:
  - half load at 0x21 → resp_err=1, resp_rdata=0, no mem_read/mem_write pulse;
  - size=11 → same response.
- Reset in WRITE of a byte store:
  - mem_write stays 0 and memory is unchanged;
  - the following cycle shows state IDLE, resp_valid=00, and the pointer back at lane 0.
